// File: rtl/alu593_stim_gen_pkg.sv
// Shared types and constants for the ALU593 stimulus generator:
// operation codes, stimulus modes, FSM states and the LFSR step function.
package ALU593_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOT   = 4'h5,
        OP_SHL   = 4'h6,
        OP_SHR   = 4'h7,
        OP_SRA   = 4'h8,
        OP_ROL   = 4'h9,
        OP_ROR   = 4'hA,
        OP_INC   = 4'hB,
        OP_DEC   = 4'hC,
        OP_CMP   = 4'hD,
        OP_PASSA = 4'hE,
        OP_PASSB = 4'hF
    } operation_t;

    typedef enum logic [1:0] {
        MODE_RANDOM   = 2'd0,
        MODE_OP_SWEEP = 2'd1,
        MODE_CORNER   = 2'd2,
        MODE_RSVD     = 2'd3
    } stim_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // One Galois right-shift step: shift out bit 0 and fold the taps back in when it was set.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/alu593_lfsr32.sv
// 32-bit Galois LFSR; reset and load both restore the seed, step advances one position.
module alu593_lfsr32
    import ALU593_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] state
);

    logic [31:0] r_state;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_state <= seed;
        end else if (step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/alu593_stim_gen.sv
// ALU593 stimulus generator: offers a valid/ready stream of (op, A, B) transactions
// drawn from an LFSR, an op sweep or a corner-value walk, NUM_TXN per run.
module alu593_stim_gen
    import ALU593_pkg::*;
#(
    parameter int          DATA_W  = 8,
    parameter int          NUM_TXN = 1000,
    parameter logic [31:0] SEED    = 32'hACE1_2345
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    output logic [3:0]        op,
    output logic [DATA_W-1:0] iA,
    output logic [DATA_W-1:0] iB,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       txn_cnt
);

    localparam logic [15:0] LAST_CNT = 16'(NUM_TXN - 1);

    fsm_state_t  r_state;
    fsm_state_t  w_state_nxt;
    stim_mode_t  r_mode;
    logic [15:0] r_txn_cnt;
    logic        r_done;

    logic [31:0]       w_lfsr;
    logic              w_valid;
    logic              w_start;
    logic              w_abort;
    logic              w_xfer;
    logic              w_finish;
    logic [DATA_W-1:0] w_rnd_a;
    logic [DATA_W-1:0] w_rnd_b;
    logic [3:0]        w_op;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic              w_unused_lfsr;

    function automatic logic [DATA_W-1:0] pick_operand(input logic [1:0] sel,
                                                       input logic [DATA_W-1:0] field);
        case (sel)
            2'd0:    return '0;
            2'd3:    return '1;
            default: return field;
        endcase
    endfunction

    assign w_valid  = (r_state == ST_RUN);
    assign w_start  = start && (r_state != ST_RUN);
    assign w_abort  = abort && (r_state == ST_RUN);
    // Abort wins over a coincident handshake: such a transfer is not counted.
    assign w_xfer   = w_valid && ready && !w_abort;
    assign w_finish = w_xfer && (r_txn_cnt == LAST_CNT);

    alu593_lfsr32 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (w_start),
        .seed  (SEED),
        .step  (w_xfer),
        .state (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_finish) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode    <= MODE_RANDOM;
            r_txn_cnt <= 16'd0;
            r_done    <= 1'b0;
        end else if (w_start) begin
            r_mode    <= stim_mode_t'(mode);
            r_txn_cnt <= 16'd0;
            r_done    <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_txn_cnt <= r_txn_cnt + 16'd1;
            end
            if (w_finish) begin
                r_done <= 1'b1;
            end
        end
    end

    // Operand fields: A from bits [6 +: W] gated by [5:4], B from [6+W +: W] gated by [31:30].
    assign w_rnd_a = pick_operand(w_lfsr[5:4],   w_lfsr[6 +: DATA_W]);
    assign w_rnd_b = pick_operand(w_lfsr[31:30], w_lfsr[6+DATA_W +: DATA_W]);
    assign w_unused_lfsr = ^w_lfsr;

    // Outputs depend only on LFSR and count, which freeze while stalled, so they hold.
    always_comb begin
        w_op = 4'd0;
        w_a  = '0;
        w_b  = '0;
        case (r_mode)
            MODE_OP_SWEEP: begin
                w_op = r_txn_cnt[3:0];
                w_a  = w_rnd_a;
                w_b  = w_rnd_b;
            end
            MODE_CORNER: begin
                w_op = r_txn_cnt[5:2];
                w_a  = {DATA_W{r_txn_cnt[1]}};
                w_b  = {DATA_W{r_txn_cnt[0]}};
            end
            default: begin
                w_op = w_lfsr[3:0];
                w_a  = w_rnd_a;
                w_b  = w_rnd_b;
            end
        endcase
        if (!w_valid) begin
            w_op = 4'd0;
            w_a  = '0;
            w_b  = '0;
        end
    end

    assign op      = w_op;
    assign iA      = w_a;
    assign iB      = w_b;
    assign valid   = w_valid;
    assign busy    = w_valid;
    assign done    = r_done;
    assign txn_cnt = r_txn_cnt;

endmodule

// File: tb/tb_alu593_stim_gen.sv
// Randomised self-checking bench for alu593_stim_gen against a rule-level reference model.
module tb_alu593_stim_gen;

    localparam int          DW    = 8;
    localparam int          NTXN  = 8;
    localparam logic [31:0] SEEDV = 32'hACE1_2345;
    localparam int          MAXV  = (1 << DW) - 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [1:0]    mode;
    logic [3:0]    op;
    logic [DW-1:0] iA;
    logic [DW-1:0] iB;
    logic          valid;
    logic          ready;
    logic          busy;
    logic          done;
    logic [15:0]   txn_cnt;

    int n_checks = 0;
    int n_errs   = 0;

    alu593_stim_gen #(.DATA_W(DW), .NUM_TXN(NTXN), .SEED(SEEDV)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .mode    (mode),
        .op      (op),
        .iA      (iA),
        .iB      (iB),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .txn_cnt (txn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        if (s % 2 == 1) return (s >> 1) ^ 32'h8020_0003;
        return s >> 1;
    endfunction

    function automatic int ref_operand(input int sel, input int field);
        if (sel == 0) return 0;
        if (sel == 3) return MAXV;
        return field;
    endfunction

    // Expected {op, A, B} for transaction k of a run in mode m with LFSR value s.
    function automatic logic [4+2*DW-1:0] ref_txn(input int m, input int k, input logic [31:0] s);
        int opv, a, b;
        if (m == 2) begin
            opv = (k / 4) % 16;
            a   = ((k % 4) >= 2) ? MAXV : 0;
            b   = ((k % 4) % 2 == 1) ? MAXV : 0;
        end else begin
            opv = (m == 1) ? (k % 16) : int'(s % 16);
            a   = ref_operand(int'((s >> 4) % 4),  int'((s >> 6) & MAXV));
            b   = ref_operand(int'((s >> 30) % 4), int'((s >> (6 + DW)) & MAXV));
        end
        return {opv[3:0], a[DW-1:0], b[DW-1:0]};
    endfunction

    function automatic logic [31:0] obs_txn();
        return 32'({op, iA, iB});
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_busy"},  32'(busy),  32'd0);
        check({tag, "_op"},    32'(op),    32'd0);
        check({tag, "_iA"},    32'(iA),    32'd0);
        check({tag, "_iB"},    32'(iB),    32'd0);
    endtask

    // Full run in mode m with random ready stalls; every offered transaction is compared.
    task automatic run_check(input int m, input int stall_pct);
        logic [31:0] s;
        int k;
        int cyc;
        s   = SEEDV;
        k   = 0;
        cyc = 0;
        mode  = 2'(m);
        ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (k < NTXN && cyc < 200) begin
            check("run_valid", 32'(valid), 32'd1);
            check("run_done_low", 32'(done), 32'd0);
            check("run_cnt", 32'(txn_cnt), k);
            check("run_txn", obs_txn(), 32'(ref_txn(m, k, s)));
            ready = ($urandom_range(0, 99) >= stall_pct);
            tick();
            if (ready) begin
                k++;
                s = ref_step(s);
            end
            cyc++;
        end
        ready = 1'b0;
        check("run_all_txn", k, NTXN);
        check("run_done", 32'(done), 32'd1);
        check("run_end_cnt", 32'(txn_cnt), NTXN);
        check_idle_outputs("run_end");
    endtask

    logic [31:0] rec [5];
    logic [31:0] s4;
    logic [31:0] exp4;
    logic [7:0]  corner_a [4];
    logic [7:0]  corner_b [4];

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 2'd0;
        ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset, then idle
        for (int i = 0; i < 10; i++) tick();
        check_idle_outputs("idle");
        check("idle_done", 32'(done), 32'd0);
        check("idle_cnt", 32'(txn_cnt), 32'd0);

        // Mode 1, ready high: op sweep and done on the last transfer
        mode  = 2'd1;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NTXN; i++) begin
            check("sweep_valid", 32'(valid), 32'd1);
            check("sweep_op", 32'(op), i);
            check("sweep_done_early", 32'(done), 32'd0);
            tick();
        end
        check("sweep_done", 32'(done), 32'd1);
        check("sweep_cnt", 32'(txn_cnt), NTXN);
        check_idle_outputs("sweep_end");
        ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("sweep_done_sticky", 32'(done), 32'd1);

        // Mode 2 corner walk
        corner_a[0] = 8'h00; corner_b[0] = 8'h00;
        corner_a[1] = 8'h00; corner_b[1] = 8'hFF;
        corner_a[2] = 8'hFF; corner_b[2] = 8'h00;
        corner_a[3] = 8'hFF; corner_b[3] = 8'hFF;
        mode  = 2'd2;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("corner_done_cleared", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("corner_op", 32'(op), 32'd0);
            check("corner_a", 32'(iA), 32'(corner_a[i]));
            check("corner_b", 32'(iB), 32'(corner_b[i]));
            tick();
        end
        check("corner_op5", 32'(op), 32'd1);
        for (int c = 0; c < 20 && busy; c++) tick();
        check("corner_finished", 32'(busy), 32'd0);
        ready = 1'b0;

        // Mode 0 with a 5-cycle stall on the first transaction
        mode  = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        s4   = SEEDV;
        exp4 = 32'(ref_txn(0, 0, s4));
        check("stall_first", obs_txn(), exp4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold", obs_txn(), exp4);
            check("stall_valid", 32'(valid), 32'd1);
            check("stall_cnt", 32'(txn_cnt), 32'd0);
        end
        ready = 1'b1;
        for (int k = 0; k < NTXN; k++) begin
            check("stall_seq", obs_txn(), 32'(ref_txn(0, k, s4)));
            tick();
            s4 = ref_step(s4);
        end
        check("stall_done", 32'(done), 32'd1);
        ready = 1'b0;

        // Abort coincident with the third transfer
        mode  = 2'd0;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_pre_cnt", 32'(txn_cnt), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle_outputs("abort");
        check("abort_done", 32'(done), 32'd0);
        check("abort_cnt", 32'(txn_cnt), 32'd2);
        tick();
        check("abort_stays_idle", 32'(valid), 32'd0);
        check("abort_cnt_hold", 32'(txn_cnt), 32'd2);
        ready = 1'b0;

        // Reset mid-run at txn_cnt=5, then replay from SEED
        mode  = 2'd0;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        s4 = SEEDV;
        for (int k = 0; k < 5; k++) begin
            rec[k] = obs_txn();
            check("rst_pre_seq", rec[k], 32'(ref_txn(0, k, s4)));
            s4 = ref_step(s4);
            tick();
        end
        check("rst_pre_cnt", 32'(txn_cnt), 32'd5);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_idle_outputs("rst");
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(txn_cnt), 32'd0);
        tick();
        check("rst_idle_valid", 32'(valid), 32'd0);
        check("rst_idle_done", 32'(done), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("rst_replay", obs_txn(), rec[k]);
            tick();
        end
        for (int c = 0; c < 20 && busy; c++) tick();
        check("rst_replay_done", 32'(done), 32'd1);
        ready = 1'b0;

        // Randomised runs across all modes including reserved
        for (int r = 0; r < 8; r++) begin
            run_check(int'($urandom_range(0, 3)), int'($urandom_range(0, 60)));
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu593_stim_gen.md
ALU593_STIM_GEN -- requirements
Module: alu593_stim_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with all state updated on posedge clk.
REQ-002 Parameter DATA_W, default 8, SHALL set the operand width; legal values are 4..12.
REQ-003 Parameter NUM_TXN, default 1000, SHALL set the transactions per run; legal values are 1..65535.
REQ-004 Parameter SEED, default 32'hACE1_2345, SHALL set the LFSR load value; it SHALL be nonzero.
REQ-005 Ports SHALL be:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  begins a run; honoured only in IDLE or DONE.
- abort  in  1  terminates a run.
- mode  in  2  0=random, 1=op sweep, 2=corner walk, 3=reserved (treated as 0).
- op  out  4  operation_t code.
- iA  out  DATA_W  operand A.
- iB  out  DATA_W  operand B.
- valid  out  1  transaction offered.
- ready  in  1  DUT accepts.
- busy  out  1  run in progress.
- done  out  1  run completed; sticky.
- txn_cnt  out  16  accepted transactions this run.

Function
REQ-006 The block SHALL use FSM states IDLE, RUN and DONE.
REQ-007 On start in IDLE or DONE, the block SHALL, on the next edge:
- enter RUN;
- latch mode;
- load the LFSR with SEED;
- clear txn_cnt and done;
- assert valid with the first transaction.
REQ-008 A transfer SHALL occur on any edge where valid && ready are both high.
REQ-009 While valid is high and ready is low, op, iA and iB SHALL be held stable.
REQ-010 On each transfer:
- txn_cnt SHALL increment;
- the LFSR SHALL advance by one step;
- the next transaction SHALL be presented on the following cycle with no bubble.
REQ-011 The LFSR SHALL be a 32-bit Galois right-shift LFSR with tap mask 32'h8020_0003, and SHALL advance only on transfer.
REQ-012 In mode 0:
- op SHALL be lfsr[3:0].
- iA SHALL be all-zeros if lfsr[5:4]==0, all-ones if lfsr[5:4]==3, and lfsr[6 +: DATA_W] otherwise.
- iB SHALL be all-zeros if lfsr[31:30]==0, all-ones if lfsr[31:30]==3, and lfsr[6+DATA_W +: DATA_W] otherwise.
REQ-013 In mode 1, op SHALL equal txn_cnt[3:0] (wrapping 15->0), and iA/iB SHALL follow REQ-012.
REQ-014 In mode 2, op SHALL equal txn_cnt[5:2] and {iA,iB} SHALL follow txn_cnt[1:0]:
- 0: (0, 0)
- 1: (0, max)
- 2: (max, 0)
- 3: (max, max)
REQ-015 The transfer that makes txn_cnt equal NUM_TXN SHALL move the FSM to DONE on that edge, drop valid and assert done.
REQ-016 Abort in RUN SHALL take precedence over a simultaneous transfer:
- the FSM moves to IDLE next edge and valid drops;
- done stays low;
- txn_cnt holds its last value and does not count the coincident transfer.
REQ-017 Start during RUN SHALL be ignored; start and abort together in IDLE or DONE SHALL start a run.
REQ-018 busy SHALL be high exactly in RUN.
REQ-019 In DONE, done SHALL stay high until the next start or reset.

Reset
REQ-020 Reset SHALL override all inputs and SHALL:
- place the FSM in IDLE;
- drive valid=0, busy=0, done=0, txn_cnt=0, op=0, iA=0, iB=0;
- load the LFSR with SEED.
REQ-021 Reset asserted mid-run SHALL abandon the run with no done pulse, and the first cycle after deassertion SHALL be IDLE.

Structure
REQ-022 operation_t (4-bit) and the new enum stim_mode_t SHALL live in ALU593_pkg; the LFSR tap mask SHALL be a package localparam.
REQ-023 The LFSR SHALL be a separate sub-module, alu593_lfsr32, with ports clk, reset, load, seed, step and state.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Reset, then idle 10 cycles -> valid=0, busy=0, done=0, txn_cnt=0.
- NUM_TXN=8, mode 1, ready tied high, one start pulse -> eight consecutive valid cycles, op sequence 0..7; done rises on the edge of the 8th transfer; txn_cnt=8.
- Mode 2, DATA_W=8, ready high -> first four transactions (op 0): (00,00), (00,FF), (FF,00), (FF,FF); the fifth has op=1.
- Mode 0, ready low for 5 cycles after valid -> op/iA/iB unchanged across all 5 cycles; the LFSR does not advance; the sequence matches a golden model from SEED.
- Abort coincident with the 3rd transfer -> next cycle IDLE, valid=0, done=0, txn_cnt=2.
- Reset asserted during RUN at txn_cnt=5 -> next cycle all outputs at reset values; a new start replays the SEED sequence identically.
